descramble64b66b: RTL and testbench

Receive-side counterpart of the 64b/66b transmit scrambler. It sits between the RX gearbox and the 64b/66b decoder. It self-synchronously descrambles each 64-bit payload with polynomial x^58 + x^39 + 1, passes the sync header and sequence number through, and runs a block-lock state machine on the sync headers. When lock is not held, the lock machine drives a bit-slip request back to the gearbox.

---
 rtl/pcs64b66b_pkg.sv | 39 +++
 rtl/descramble64b66b_if.sv | 28 ++
 rtl/block_lock_fsm.sv | 114 +++++++++++
 rtl/descramble64b66b.sv | 81 ++++++++
 tb/tb_descramble64b66b.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/pcs64b66b_pkg.sv
// Shared 64b/66b PCS definitions: sync headers, lock FSM states, lock-machine
// default parameters and the descrambler polynomial taps.
package pcs64b66b_pkg;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned HEAD_W = 2;
   localparam int unsigned SEQ_W  = 6;
   localparam int unsigned SCR_W  = 58;

   // x^58 + x^39 + 1 seen from the 58-bit history register (s[0] is oldest)
   localparam int unsigned TAP_A = 0;
   localparam int unsigned TAP_B = 19;

   localparam logic [HEAD_W-1:0] SH_DATA = 2'b01;
   localparam logic [HEAD_W-1:0] SH_CTRL = 2'b10;

   localparam int unsigned LOCK_CNT_DEF   = 64;
   localparam int unsigned UNLOCK_CNT_DEF = 16;
   localparam int unsigned WIN_CNT_DEF    = 64;
   localparam int unsigned SLIP_WAIT_DEF  = 32;

   typedef enum logic [1:0] {
      HUNT     = 2'd0,
      LOCKED   = 2'd1,
      SLIPWAIT = 2'd2
   } lock_state_e;

   // One received beat as presented on the output side
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [HEAD_W-1:0] head;
      logic [SEQ_W-1:0]  seq;
   } beat_t;

   function automatic logic sh_valid(input logic [HEAD_W-1:0] h);
      return (h == SH_DATA) || (h == SH_CTRL);
   endfunction

endpackage

// File: rtl/descramble64b66b_if.sv
// Gearbox-side and decoder-side signals of the RX descrambler.
//   master: drives data_i/head_i/seq_i/en, observes the outputs
//   slave : the descrambler itself
interface descramble64b66b_if;
   import pcs64b66b_pkg::*;

   logic [DATA_W-1:0] data_i;
   logic [HEAD_W-1:0] head_i;
   logic [SEQ_W-1:0]  seq_i;
   logic              en;
   logic [DATA_W-1:0] data_o;
   logic [HEAD_W-1:0] head_o;
   logic [SEQ_W-1:0]  seq_o;
   logic              vld;
   logic              block_lock;
   logic              slip_o;

   modport master (
      output data_i, head_i, seq_i, en,
      input  data_o, head_o, seq_o, vld, block_lock, slip_o
   );

   modport slave (
      input  data_i, head_i, seq_i, en,
      output data_o, head_o, seq_o, vld, block_lock, slip_o
   );

endinterface

// File: rtl/block_lock_fsm.sv
// Block-lock state machine on 64b/66b sync headers.
// Ports: clk, rst_n, head_i (sync header), en (beat valid),
//        block_lock (registered lock status), slip_o (one-cycle slip request).
module block_lock_fsm
   import pcs64b66b_pkg::*;
#(
   parameter int unsigned LOCK_CNT   = LOCK_CNT_DEF,
   parameter int unsigned UNLOCK_CNT = UNLOCK_CNT_DEF,
   parameter int unsigned WIN_CNT    = WIN_CNT_DEF,
   parameter int unsigned SLIP_WAIT  = SLIP_WAIT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [HEAD_W-1:0] head_i,
   input  logic              en,
   output logic              block_lock,
   output logic              slip_o
);

   // sh_cnt serves both the acquire run and the monitoring window
   localparam int unsigned SH_MAX = (LOCK_CNT > WIN_CNT) ? LOCK_CNT : WIN_CNT;
   localparam int unsigned SH_W   = $clog2(SH_MAX + 1);
   localparam int unsigned BAD_W  = $clog2(UNLOCK_CNT + 1);
   localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);

   lock_state_e       state_q, state_d;
   logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d;
   logic [BAD_W-1:0]  bad_cnt_q, bad_cnt_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              lock_q, lock_d;
   logic              slip_q, slip_d;
   logic              hv_c;

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= HUNT;
         sh_cnt_q   <= '0;
         bad_cnt_q  <= '0;
         wait_cnt_q <= '0;
         lock_q     <= 1'b0;
         slip_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sh_cnt_q   <= sh_cnt_d;
         bad_cnt_q  <= bad_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         lock_q     <= lock_d;
         slip_q     <= slip_d;
      end
   end

   // Next-state logic; everything holds on en=0 beats, slip is a pulse
   always_comb begin
      state_d    = state_q;
      sh_cnt_d   = sh_cnt_q;
      bad_cnt_d  = bad_cnt_q;
      wait_cnt_d = wait_cnt_q;
      lock_d     = lock_q;
      slip_d     = 1'b0;
      hv_c       = sh_valid(head_i);

      if (en) begin
         unique case (state_q)
            HUNT: begin
               if (!hv_c) begin
                  slip_d   = 1'b1;
                  sh_cnt_d = '0;
                  state_d  = SLIPWAIT;
               end else if (sh_cnt_q == SH_W'(LOCK_CNT - 1)) begin
                  sh_cnt_d = '0;
                  lock_d   = 1'b1;
                  state_d  = LOCKED;
               end else begin
                  sh_cnt_d = sh_cnt_q + SH_W'(1);
               end
            end
            SLIPWAIT: begin
               if (wait_cnt_q == WAIT_W'(SLIP_WAIT - 1)) begin
                  wait_cnt_d = '0;
                  state_d    = HUNT;
               end else begin
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               end
            end
            LOCKED: begin
               // Unlock takes priority over the window boundary
               if (!hv_c && (bad_cnt_q == BAD_W'(UNLOCK_CNT - 1))) begin
                  sh_cnt_d  = '0;
                  bad_cnt_d = '0;
                  lock_d    = 1'b0;
                  slip_d    = 1'b1;
                  state_d   = SLIPWAIT;
               end else if (sh_cnt_q == SH_W'(WIN_CNT - 1)) begin
                  sh_cnt_d  = '0;
                  bad_cnt_d = '0;
               end else begin
                  sh_cnt_d = sh_cnt_q + SH_W'(1);
                  if (!hv_c) begin
                     bad_cnt_d = bad_cnt_q + BAD_W'(1);
                  end
               end
            end
            default: begin
               state_d = HUNT;
            end
         endcase
      end
   end

   assign block_lock = lock_q;
   assign slip_o     = slip_q;

endmodule

// File: rtl/descramble64b66b.sv
// RX self-synchronous descrambler (x^58 + x^39 + 1) with sync-header
// pass-through and block-lock / bit-slip control.
// Ports: clk, rst_n (async active-low), bus (slave side of
//        descramble64b66b_if: data/head/seq/en in, data/head/seq/vld,
//        block_lock, slip_o out).
module descramble64b66b
   import pcs64b66b_pkg::*;
#(
   parameter int unsigned LOCK_CNT   = LOCK_CNT_DEF,
   parameter int unsigned UNLOCK_CNT = UNLOCK_CNT_DEF,
   parameter int unsigned WIN_CNT    = WIN_CNT_DEF,
   parameter int unsigned SLIP_WAIT  = SLIP_WAIT_DEF
) (
   input logic               clk,
   input logic               rst_n,
   descramble64b66b_if.slave bus
);

   // Bit-serial descramble of one beat; returns {next history, payload}.
   // History shifts in received bits, which makes the descrambler self-syncing.
   function automatic logic [SCR_W+DATA_W-1:0] descramble(
      input logic [DATA_W-1:0] r,
      input logic [SCR_W-1:0]  s
   );
      logic [SCR_W-1:0]  st;
      logic [DATA_W-1:0] d;
      st = s;
      d  = '0;
      for (int i = 0; i < int'(DATA_W); i++) begin
         d[i] = r[i] ^ st[TAP_B] ^ st[TAP_A];
         st   = {r[i], st[SCR_W-1:1]};
      end
      return {st, d};
   endfunction

   logic [SCR_W-1:0]  scr_q, scr_d;
   logic [DATA_W-1:0] plain_c;
   beat_t             out_q;
   logic              vld_q;

   assign {scr_d, plain_c} = descramble(bus.data_i, scr_q);

   // Descrambler history and output beat register; both hold across gaps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scr_q      <= '1;
         out_q.data <= '1;
         out_q.head <= '0;
         out_q.seq  <= '0;
         vld_q      <= 1'b0;
      end else begin
         vld_q <= bus.en;
         if (bus.en) begin
            scr_q      <= scr_d;
            out_q.data <= plain_c;
            out_q.head <= bus.head_i;
            out_q.seq  <= bus.seq_i;
         end
      end
   end

   assign bus.data_o = out_q.data;
   assign bus.head_o = out_q.head;
   assign bus.seq_o  = out_q.seq;
   assign bus.vld    = vld_q;

   block_lock_fsm #(
      .LOCK_CNT   (LOCK_CNT),
      .UNLOCK_CNT (UNLOCK_CNT),
      .WIN_CNT    (WIN_CNT),
      .SLIP_WAIT  (SLIP_WAIT)
   ) u_lock (
      .clk        (clk),
      .rst_n      (rst_n),
      .head_i     (bus.head_i),
      .en         (bus.en),
      .block_lock (bus.block_lock),
      .slip_o     (bus.slip_o)
   );

endmodule

// File: tb/tb_descramble64b66b.sv
// Bench for descramble64b66b: a line-level scrambler model feeds the DUT and
// a header-counting lock model predicts block_lock / slip_o.
module tb_descramble64b66b;
   import pcs64b66b_pkg::*;

   localparam int unsigned LOCK   = 64;
   localparam int unsigned UNLOCK = 16;
   localparam int unsigned WIN    = 64;
   localparam int unsigned SWAIT  = 32;

   localparam int M_HUNT = 0;
   localparam int M_LOCK = 1;
   localparam int M_WAIT = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   descramble64b66b_if bus ();

   descramble64b66b #(
      .LOCK_CNT   (LOCK),
      .UNLOCK_CNT (UNLOCK),
      .WIN_CNT    (WIN),
      .SLIP_WAIT  (SLIP_WAIT_DEF)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Line history for the scrambler model: bits already sent, newest last
   bit line_hist[$];

   function automatic void scr_reset();
      line_hist.delete();
      repeat (58) line_hist.push_back(1'b1);
   endfunction

   // Transmit scrambler: out bit = in ^ (line bit 39 back) ^ (line bit 58 back)
   function automatic logic [63:0] scramble(input logic [63:0] p);
      logic [63:0] c;
      for (int i = 0; i < 64; i++) begin
         c[i] = p[i] ^ line_hist[line_hist.size() - 39] ^ line_hist[line_hist.size() - 58];
         line_hist.push_back(c[i]);
         void'(line_hist.pop_front());
      end
      return c;
   endfunction

   // Lock model: counts of good headers, beats left to ignore, window tallies
   int mode, good_run, wait_left, win_pos, bad_in_win;
   logic [63:0] e_data;
   logic [1:0]  e_head;
   logic [5:0]  e_seq;
   logic        e_vld, e_lock, e_slip;
   bit          data_known, skip_next;

   function automatic void model_reset();
      mode = M_HUNT; good_run = 0; wait_left = 0; win_pos = 0; bad_in_win = 0;
      e_data = '1; e_head = 2'b00; e_seq = '0;
      e_vld = 1'b0; e_lock = 1'b0; e_slip = 1'b0;
      data_known = 1'b1;
   endfunction

   function automatic void lock_model(input logic [1:0] h);
      bit ok;
      ok = (h == 2'b01) || (h == 2'b10);
      case (mode)
         M_HUNT: begin
            if (!ok) begin
               e_slip = 1'b1; mode = M_WAIT; wait_left = SWAIT; good_run = 0;
            end else begin
               good_run++;
               if (good_run == LOCK) begin
                  mode = M_LOCK; win_pos = 0; bad_in_win = 0;
               end
            end
         end
         M_WAIT: begin
            wait_left--;
            if (wait_left == 0) begin
               mode = M_HUNT; good_run = 0;
            end
         end
         default: begin
            win_pos++;
            if (!ok) bad_in_win++;
            if (bad_in_win == UNLOCK) begin
               e_slip = 1'b1; mode = M_WAIT; wait_left = SWAIT;
               win_pos = 0; bad_in_win = 0;
            end else if (win_pos == WIN) begin
               win_pos = 0; bad_in_win = 0;
            end
         end
      endcase
      e_lock = (mode == M_LOCK);
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [1:0] good_h();
      return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
   endfunction

   function automatic logic [1:0] bad_h();
      return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
   endfunction

   // One clock: drive at negedge, check #1 after the following posedge
   task automatic step(input bit en, input logic [63:0] p, input logic [1:0] h, input logic [5:0] s);
      bus.en     = en;
      bus.head_i = h;
      bus.seq_i  = s;
      e_slip     = 1'b0;
      e_vld      = en;
      if (en) begin
         bus.data_i = scramble(p);
         e_data     = p;
         e_head     = h;
         e_seq      = s;
         lock_model(h);
         data_known = !skip_next;
         skip_next  = 1'b0;
      end else begin
         bus.data_i = rnd64();
      end
      @(posedge clk);
      #1;
      chk("vld", 64'(bus.vld), 64'(e_vld));
      chk("head", 64'(bus.head_o), 64'(e_head));
      chk("seq", 64'(bus.seq_o), 64'(e_seq));
      if (data_known) chk("data", bus.data_o, e_data);
      chk("block_lock", 64'(bus.block_lock), 64'(e_lock));
      chk("slip", 64'(bus.slip_o), 64'(e_slip));
      @(negedge clk);
   endtask

   // Asynchronous reset pulse; with_scr also restarts the scrambler model
   task automatic do_reset(input bit with_scr);
      bus.en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("rst_data", bus.data_o, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("rst_head", 64'(bus.head_o), 64'd0);
      chk("rst_seq", 64'(bus.seq_o), 64'd0);
      chk("rst_vld", 64'(bus.vld), 64'd0);
      chk("rst_lock", 64'(bus.block_lock), 64'd0);
      chk("rst_slip", 64'(bus.slip_o), 64'd0);
      model_reset();
      if (with_scr) scr_reset();
      else skip_next = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.en = 1'b0; bus.data_i = '0; bus.head_i = '0; bus.seq_i = '0;
      skip_next = 1'b0;
      scr_reset();
      model_reset();
      @(negedge clk);
      do_reset(1'b1);

      // Loopback: directed words then random words with random gaps
      step(1'b1, 64'h0, 2'b01, 6'd0);
      step(1'b1, 64'h1, 2'b10, 6'd1);
      step(1'b1, 64'hDEADBEEF_0123_4567, 2'b01, 6'd2);
      for (int i = 0; i < 1000; i++) begin
         step(1'b1, rnd64(), good_h(), 6'(i));
         if ($urandom_range(0, 9) == 0) step(1'b0, rnd64(), bad_h(), 6'($urandom));
      end
      chk("loopback_locked", 64'(bus.block_lock), 64'd1);

      // Gap of 7 idle cycles, then data must still descramble correctly
      repeat (7) step(1'b0, rnd64(), bad_h(), 6'($urandom));
      repeat (5) step(1'b1, rnd64(), good_h(), 6'($urandom));

      // Acquire, then a window with 15 bad headers, then one with 16
      do_reset(1'b1);
      for (int i = 0; i < 64; i++) step(1'b1, rnd64(), good_h(), 6'(i));
      for (int i = 0; i < 64; i++)
         step(1'b1, rnd64(), ((i % 4 == 0) && (i < 60)) ? bad_h() : good_h(), 6'(i));
      chk("win15_held", 64'(bus.block_lock), 64'd1);
      for (int i = 0; i < 50; i++)
         step(1'b1, rnd64(), (i % 3 == 0) ? bad_h() : good_h(), 6'(i));
      chk("win16_dropped", 64'(bus.block_lock), 64'd0);

      // Hunt slip: bad header on beat 10, next 32 bad headers ignored
      do_reset(1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, rnd64(), good_h(), 6'(i));
      step(1'b1, rnd64(), 2'b11, 6'd10);
      for (int i = 0; i < 32; i++) step(1'b1, rnd64(), bad_h(), 6'(i));
      for (int i = 0; i < 63; i++) step(1'b1, rnd64(), good_h(), 6'(i));
      chk("hunt_63_unlocked", 64'(bus.block_lock), 64'd0);
      step(1'b1, rnd64(), good_h(), 6'd63);
      chk("hunt_64_locked", 64'(bus.block_lock), 64'd1);

      // Scrambler runs ahead 5 beats, descrambler reset mid-lock: resyncs after one beat
      repeat (5) void'(scramble(rnd64()));
      do_reset(1'b0);

      // Soak: mostly valid headers, occasional bad ones, random gaps
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 6) != 0, rnd64(),
              ($urandom_range(0, 29) == 0) ? bad_h() : good_h(), 6'(i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
